por_reset_sequencer: RTL



---
 rtl/por_seq_pkg.sv | 17 +
 rtl/por_seq_timer.sv | 36 +++
 rtl/por_reset_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/por_seq_pkg.sv
// Shared types for the power-on reset sequencer.
//   por_seq_state_e : sequencer state encoding, driven directly onto seq_state
//   max_u           : elaboration-time helper for the delay-width check
package por_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    LOCK_WAIT = 2'd1,
    RELEASE   = 2'd2,
    READY     = 2'd3
  } por_seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/por_seq_timer.sv
// Shared delay counter for the reset sequencer.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : count enable
//   i_limit    : runtime terminal-count value
//   o_tc_c     : combinational terminal-count flag (count == limit)
module por_seq_timer
  import por_seq_pkg::*;
#(
  parameter int unsigned DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [DELAY_W-1:0] i_limit,
  output logic               o_tc_c
);

  logic [DELAY_W-1:0] r_cnt;

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + DELAY_W'(1);
    end
  end

  assign o_tc_c = (r_cnt == i_limit);

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: holds NUM_CH reset domains in reset for INIT_DELAY
// cycles after por_n release, releases them in ascending order STAGGER cycles
// apart, then raises system_ready and forwards data_in to data_out.
// Optional feature macro: POR_SEQ_PLL_LOCK_EN (adds pll_lock and LOCK_WAIT).
// Ports:
//   clk          : system clock
//   por_n        : async active-low power-on reset
//   sw_rst_req   : soft re-sequence request (honoured in RELEASE/READY)
//   pll_lock     : PLL lock indication (only with POR_SEQ_PLL_LOCK_EN)
//   data_in      : data forwarded once ready
//   rst_out_n    : per-domain active-low resets, bit 0 released first
//   system_ready : high once every domain is released
//   data_out     : registered data_in while READY
//   seq_state    : current state encoding
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DELAY_W    = 8,
  parameter int unsigned INIT_DELAY = 16,
  parameter int unsigned STAGGER    = 4
) (
  input  logic              clk,
  input  logic              por_n,
  input  logic              sw_rst_req,
`ifdef POR_SEQ_PLL_LOCK_EN
  input  logic              pll_lock,
`endif
  input  logic [DATA_W-1:0] data_in,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              system_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        seq_state
);

  localparam int unsigned IDX_W   = $clog2(NUM_CH + 1);
  localparam int unsigned MAX_DLY = max_u(INIT_DELAY, STAGGER);

  // Reject configurations the counter or sequence cannot represent
  if (NUM_CH < 1 || INIT_DELAY < 1 || STAGGER < 1 ||
      (longint'(MAX_DLY) - 1) > ((longint'(1) << DELAY_W) - 1)) begin : g_cfg_err
    $error("por_reset_sequencer: invalid parameter configuration");
  end

  por_seq_state_e    r_state,  w_nxt_state;
  logic [IDX_W-1:0]  r_idx,    w_nxt_idx;
  logic [NUM_CH-1:0] r_rst_n,  w_nxt_rst_n;
  logic              r_ready,  w_nxt_ready;
  logic [DATA_W-1:0] r_data,   w_nxt_data;

  logic               w_clr;
  logic               w_en;
  logic [DELAY_W-1:0] w_limit;
  logic               w_tc;
  logic               w_resync;

  // Re-sequence trigger; only meaningful once a release has started
`ifdef POR_SEQ_PLL_LOCK_EN
  assign w_resync = (sw_rst_req || !pll_lock) &&
                    (r_state == RELEASE || r_state == READY);
`else
  assign w_resync = sw_rst_req && (r_state == RELEASE || r_state == READY);
`endif

  por_seq_timer #(
    .DELAY_W (DELAY_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (por_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (w_limit),
    .o_tc_c  (w_tc)
  );

  // State and output registers
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) begin
      r_state <= HOLD;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_rst_n <= w_nxt_rst_n;
      r_ready <= w_nxt_ready;
      r_data  <= w_nxt_data;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_rst_n = r_rst_n;
    w_nxt_ready = r_ready;
    w_nxt_data  = r_data;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    w_limit     = DELAY_W'(INIT_DELAY - 1);

    case (r_state)
      HOLD: begin
        if (w_tc) begin
          w_clr = 1'b1;
`ifdef POR_SEQ_PLL_LOCK_EN
          w_nxt_state = LOCK_WAIT;
`else
          w_nxt_state = RELEASE;
          w_nxt_rst_n = NUM_CH'(1);
          w_nxt_idx   = IDX_W'(1);
`endif
        end else begin
          w_en = 1'b1;
        end
      end
`ifdef POR_SEQ_PLL_LOCK_EN
      LOCK_WAIT: begin
        w_clr = 1'b1;
        if (pll_lock) begin
          w_nxt_state = RELEASE;
          w_nxt_rst_n = NUM_CH'(1);
          w_nxt_idx   = IDX_W'(1);
        end
      end
`endif
      RELEASE: begin
        w_limit = DELAY_W'(STAGGER - 1);
        if (w_tc) begin
          w_clr = 1'b1;
          if (r_idx < IDX_W'(NUM_CH)) begin
            // Shifting in a one keeps releases in ascending bit order
            w_nxt_rst_n = (r_rst_n << 1) | NUM_CH'(1);
            w_nxt_idx   = r_idx + IDX_W'(1);
          end else begin
            w_nxt_state = READY;
            w_nxt_ready = 1'b1;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      READY: begin
        w_clr      = 1'b1;
        w_nxt_data = data_in;
      end
      default: begin
        w_clr       = 1'b1;
        w_nxt_state = HOLD;
      end
    endcase

    // Re-sequence overrides everything above
    if (w_resync) begin
      w_nxt_state = HOLD;
      w_nxt_idx   = '0;
      w_nxt_rst_n = '0;
      w_nxt_ready = 1'b0;
      w_nxt_data  = '0;
      w_clr       = 1'b1;
      w_en        = 1'b0;
    end
  end

  assign rst_out_n    = r_rst_n;
  assign system_ready = r_ready;
  assign data_out     = r_data;
  assign seq_state    = r_state;

endmodule
